// File: rtl/ula_seq_pkg.sv
// Shared opcode and state definitions for the ULA command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ula_seq_pkg;

  localparam int ULA_WIDTH = 4;

  // Opcode encoding; bits map directly onto the ULA select lines {x, y, z}.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SHL = 3'b010,
    OP_SHR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_e;

  // Sequencer states: present operands, let the ULA settle, capture, hold for consumer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/ula_seq_if.sv
// Bundle of command, ULA-drive and result signals around the sequencer.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready on input, res_valid/res_ready on output.
interface ula_seq_if #(
  parameter int WIDTH = 4
);
  // Command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_acc;
  // ULA operand/select drive and combinational result
  logic [WIDTH-1:0] ula_a;
  logic [WIDTH-1:0] ula_b;
  logic             ula_x;
  logic             ula_y;
  logic             ula_z;
  logic [WIDTH-1:0] ula_s;
  // Result channel
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, ula_s, res_ready,
    output cmd_ready, ula_a, ula_b, ula_x, ula_y, ula_z, res_valid, res_data, res_zero
  );

  // Command source / ULA / result consumer side
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, ula_s, res_ready,
    input  cmd_ready, ula_a, ula_b, ula_x, ula_y, ula_z, res_valid, res_data, res_zero
  );
endinterface

// File: rtl/ula_seq.sv
// Sequencer that drives an external ULA, captures its result and keeps an accumulator.
// Latency: accept edge N, ULA settles through N+1, result captured and res_valid high after N+2.
// Backpressure: one command in flight; cmd_ready low until the result handshake completes.
module ula_seq
  import ula_seq_pkg::*;
#(
  parameter int             WIDTH    = ULA_WIDTH,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic     clk,
  input  logic     rst,
  ula_seq_if.slave bus
);

  state_e           state_q;
  logic             cmd_ready_q;
  logic             res_valid_q;
  logic             res_zero_q;
  logic [WIDTH-1:0] res_data_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] ula_a_q;
  logic [WIDTH-1:0] ula_b_q;
  logic [2:0]       op_q;

  logic             accept;
  logic [WIDTH-1:0] ula_a_d;
  logic             res_zero_d;

  assign accept     = bus.cmd_valid && cmd_ready_q;
  // Chained operations take the last captured result instead of cmd_a.
  assign ula_a_d    = bus.cmd_acc ? acc_q : bus.cmd_a;
  assign res_zero_d = (bus.ula_s == '0);

  // Command/result FSM; every output is a register so nothing glitches between states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b1;
      acc_q       <= ACC_INIT;
      ula_a_q     <= '0;
      ula_b_q     <= '0;
      op_q        <= 3'b000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ula_a_q     <= ula_a_d;
            ula_b_q     <= bus.cmd_b;
            op_q        <= bus.cmd_op;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // Operands stay put for a whole cycle so the ULA output is stable at capture.
          state_q <= ST_CAPT;
        end
        ST_CAPT: begin
          res_data_q  <= bus.ula_s;
          res_zero_q  <= res_zero_d;
          acc_q       <= bus.ula_s;
          res_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.ula_a     = ula_a_q;
  assign bus.ula_b     = ula_b_q;
  assign bus.ula_x     = op_q[2];
  assign bus.ula_y     = op_q[1];
  assign bus.ula_z     = op_q[0];
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq with a behavioural 4-bit ULA beside it.
// Latency: checks result timing relative to the accept edge.
// Backpressure: exercises res_ready stalls, mid-operation reset and back-to-back streaming.
module tb_ula_seq;
  import ula_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ula_seq_if #(.WIDTH(4)) bus ();

  ula_seq #(.WIDTH(4), .ACC_INIT(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ULA: modulo-16 arithmetic, shifts of 4 or more give 0, 'not' ignores b.
  always_comb begin
    logic [3:0] r;
    r = 4'h0;
    case ({bus.ula_x, bus.ula_y, bus.ula_z})
      3'b000:  r = bus.ula_a + bus.ula_b;
      3'b001:  r = bus.ula_a - bus.ula_b;
      3'b010:  r = (bus.ula_b >= 4'd4) ? 4'h0 : (bus.ula_a << bus.ula_b);
      3'b011:  r = (bus.ula_b >= 4'd4) ? 4'h0 : (bus.ula_a >> bus.ula_b);
      3'b100:  r = bus.ula_a & bus.ula_b;
      3'b101:  r = bus.ula_a | bus.ula_b;
      3'b110:  r = bus.ula_a ^ bus.ula_b;
      default: r = ~bus.ula_a;
    endcase
    bus.ula_s = r;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and let the accept edge happen.
  task automatic send(input string tag, input logic [2:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic acc);
    check({tag, "_rdy_pre"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_acc   = acc;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Full command round trip with timing, operand and result checks.
  task automatic run(input string tag, input logic [2:0] op, input logic [3:0] a,
                     input logic [3:0] b, input logic acc, input logic [3:0] exp_a,
                     input logic [3:0] exp_s);
    send(tag, op, a, b, acc);
    check({tag, "_ula_a"}, bus.ula_a, exp_a);
    check({tag, "_ula_b"}, bus.ula_b, b);
    check({tag, "_xyz"}, {bus.ula_x, bus.ula_y, bus.ula_z}, op);
    check({tag, "_rdy_busy"}, bus.cmd_ready, 0);
    check({tag, "_rv_n1"}, bus.res_valid, 0);
    tick();
    check({tag, "_rv_n2"}, bus.res_valid, 0);
    tick();
    check({tag, "_rv"}, bus.res_valid, 1);
    check({tag, "_data"}, bus.res_data, exp_s);
    check({tag, "_zero"}, bus.res_zero, (exp_s == 4'h0));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_rv_done"}, bus.res_valid, 0);
    check({tag, "_rdy_done"}, bus.cmd_ready, 1);
    check({tag, "_ula_a_hold"}, bus.ula_a, exp_a);
  endtask

  logic [2:0] b2b_op  [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHR, OP_SHL, OP_SHR};
  logic [3:0] b2b_a   [8] = '{4'h1, 4'h0, 4'hC, 4'hC, 4'hC, 4'h8, 4'h0, 4'hF};
  logic [3:0] b2b_b   [8] = '{4'h2, 4'h1, 4'hA, 4'hA, 4'hA, 4'h2, 4'h1, 4'h4};
  logic       b2b_acc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0] b2b_exp [8] = '{4'h3, 4'hF, 4'h8, 4'hE, 4'h6, 4'h2, 4'h4, 4'h0};

  // Directed test sequence.
  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 4'h0;
    bus.cmd_b     = 4'h0;
    bus.cmd_acc   = 1'b0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_zero", bus.res_zero, 1);
    check("rst_ula_ab", {bus.ula_a, bus.ula_b}, 0);
    check("rst_xyz", {bus.ula_x, bus.ula_y, bus.ula_z}, 0);
    rst = 1'b0;
    tick();

    // Basic operations and boundaries
    run("add35", OP_ADD, 4'h3, 4'h5, 1'b0, 4'h3, 4'h8);
    run("sub25", OP_SUB, 4'h2, 4'h5, 1'b0, 4'h2, 4'hD);
    run("shl13", OP_SHL, 4'h1, 4'h3, 1'b0, 4'h1, 4'h8);
    run("shl14", OP_SHL, 4'h1, 4'h4, 1'b0, 4'h1, 4'h0);

    // Accumulator chain: 7+7=E, E>>1=7, ~7=8
    run("ch_add", OP_ADD, 4'h7, 4'h7, 1'b0, 4'h7, 4'hE);
    run("ch_shr", OP_SHR, 4'hF, 4'h1, 1'b1, 4'hE, 4'h7);
    run("ch_not", OP_NOT, 4'h0, 4'h9, 1'b1, 4'h7, 4'h8);

    // Backpressure: result held 5 cycles, stray command ignored
    send("bp", OP_ADD, 4'h4, 4'h5, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rv", bus.res_valid, 1);
      check("bp_data", bus.res_data, 4'h9);
      check("bp_rdy", bus.cmd_ready, 0);
      bus.cmd_valid = (i == 2);
      bus.cmd_a     = 4'hA;
      bus.cmd_b     = 4'h3;
      tick();
      bus.cmd_valid = 1'b0;
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("bp_rv_done", bus.res_valid, 0);
    check("bp_no_accept", {bus.ula_a, bus.ula_b}, {4'h4, 4'h5});
    check("bp_rdy_done", bus.cmd_ready, 1);

    // Reset while in DRIVE discards the command and clears acc (was 9)
    send("rstd", OP_ADD, 4'h1, 4'h1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstd_rdy", bus.cmd_ready, 1);
    check("rstd_rv", bus.res_valid, 0);
    tick();
    tick();
    tick();
    check("rstd_rv_later", bus.res_valid, 0);
    run("rstd_acc", OP_ADD, 4'h5, 4'h1, 1'b1, 4'h0, 4'h1);

    // Back-to-back streaming, one result every 4 cycles
    begin
      int acc_i;
      int res_i;
      int last_cyc;
      acc_i         = 0;
      res_i         = 0;
      last_cyc      = -1;
      bus.cmd_op    = b2b_op[0];
      bus.cmd_a     = b2b_a[0];
      bus.cmd_b     = b2b_b[0];
      bus.cmd_acc   = b2b_acc[0];
      bus.cmd_valid = 1'b1;
      bus.res_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && res_i < 8; cyc++) begin
        logic will_accept;
        will_accept = bus.cmd_valid && bus.cmd_ready;
        if (bus.res_valid) begin
          check("b2b_data", bus.res_data, b2b_exp[res_i]);
          if (res_i > 0) check("b2b_period", cyc - last_cyc, 4);
          last_cyc = cyc;
          res_i++;
        end
        tick();
        if (will_accept) begin
          acc_i++;
          if (acc_i < 8) begin
            bus.cmd_op  = b2b_op[acc_i];
            bus.cmd_a   = b2b_a[acc_i];
            bus.cmd_b   = b2b_b[acc_i];
            bus.cmd_acc = b2b_acc[acc_i];
          end else begin
            bus.cmd_valid = 1'b0;
          end
        end
      end
      check("b2b_count", res_i, 8);
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
